// File: rtl/logic_op_fifo.sv
// Four-mode bitwise logic unit (AND/OR/XOR/NAND) whose results are buffered in a
// DEPTH-entry show-ahead FIFO with valid/ready on both sides, occupancy and high-water mark.
module logic_op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 123,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] max_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] maxCount_q, maxCount_d;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign c         = out_valid ? mem[rdPtr_q] : '0;
    assign count     = count_q;
    assign max_count = maxCount_q;

    always_comb begin
        result = '0;
        case (op)
            2'b00:   result = a & b;
            2'b01:   result = a | b;
            2'b10:   result = a ^ b;
            default: result = ~(a & b);
        endcase
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths use every entry.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        maxCount_d = maxCount_q;
        if (clr) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (count_d > maxCount_q) begin
            maxCount_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            maxCount_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            maxCount_q <= maxCount_d;
        end
    end

    // Storage carries no reset; entries are only observable while out_valid is high.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wrPtr_q] <= result;
        end
    end

endmodule

// File: tb/tb_logic_op_fifo.sv
// Scoreboard bench for logic_op_fifo: directed scenarios plus random traffic,
// expected results queued at issue time and compared by an independent monitor.
module tb_logic_op_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 123;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] c;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] max_count;

    logic [WIDTH-1:0] scoreboard [$];
    int expCount = 0;
    int expMax   = 0;
    int total    = 0;
    int bad      = 0;

    logic [WIDTH-1:0] opConst [4];

    logic_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .count     (count),
        .max_count (max_count)
    );

    always #5 clk = ~clk;

    // Reference op computed bit by bit with plain arithmetic on 0/1 values.
    function automatic logic [WIDTH-1:0] refOp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic [1:0] mode);
        logic [WIDTH-1:0] r;
        int xi, yi, ri;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            xi = int'(x[i]);
            yi = int'(y[i]);
            case (mode)
                2'd0:    ri = xi * yi;
                2'd1:    ri = xi + yi - xi * yi;
                2'd2:    ri = (xi + yi) % 2;
                default: ri = 1 - xi * yi;
            endcase
            r[i] = (ri != 0);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                                 input logic [1:0] opIn, input logic rdy, input logic cl);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = aIn;
        b         = bIn;
        op        = opIn;
        out_ready = rdy;
        clr       = cl;
        if (v && !cl && expCount != DEPTH) begin
            scoreboard.push_back(refOp(aIn, bIn, opIn));
        end
    endtask

    task automatic asyncReset();
        @(posedge clk);
        #3;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #1;
        checkOutput("asyncRstCount", 32'(count), 0);
        checkOutput("asyncRstMax", 32'(max_count), 0);
        checkOutput("asyncRstOutValid", 32'(out_valid), 0);
        checkOutput("asyncRstInReady", 32'(in_ready), 1);
        checkOutput("asyncRstC", 32'(c), 0);
        scoreboard.delete();
        expCount = 0;
        expMax   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: mid-cycle, compare outputs with the model and advance it past the next edge.
    initial begin
        bit push, pop;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("rstCount", 32'(count), 0);
                checkOutput("rstMax", 32'(max_count), 0);
                checkOutput("rstOutValid", 32'(out_valid), 0);
                checkOutput("rstInReady", 32'(in_ready), 1);
                checkOutput("rstC", 32'(c), 0);
            end else begin
                checkOutput("count", 32'(count), 32'(expCount));
                checkOutput("maxCount", 32'(max_count), 32'(expMax));
                checkOutput("inReady", 32'(in_ready), 32'(expCount != DEPTH));
                checkOutput("outValid", 32'(out_valid), 32'(expCount != 0));
                if (expCount != 0) begin
                    if (scoreboard.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL scoreboardEmpty: got empty queue expected entry at %0t", $time);
                    end else begin
                        checkOutput("c", 32'(c), 32'(scoreboard[0]));
                    end
                end else begin
                    checkOutput("cIdle", 32'(c), 0);
                end
                push = in_valid && (expCount != DEPTH);
                pop  = out_ready && (expCount != 0);
                if (clr) begin
                    scoreboard.delete();
                    expCount = 0;
                end else begin
                    if (pop && scoreboard.size() != 0) begin
                        void'(scoreboard.pop_front());
                    end
                    expCount = expCount + int'(push) - int'(pop);
                    if (expCount > expMax) expMax = expCount;
                end
            end
        end
    end

    initial begin
        opConst[0] = 8'h30;
        opConst[1] = 8'hFC;
        opConst[2] = 8'hCC;
        opConst[3] = 8'hCF;

        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;

        // Op modes, each result visible one cycle after its push.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hF0, 8'h3C, 2'(i), 1'b0, 1'b0);
            checkOutput("opFillCount", 32'(count), 32'(i));
            if (i == 1) checkOutput("opLatencyC", 32'(c), 32'h30);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
            checkOutput("opResult", 32'(c), 32'(opConst[i]));
        end

        // Streaming through the wrap point with occupancy pinned at one.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b1, 8'(i), 8'h00, 2'd1, 1'b1, 1'b0);
            if (i >= 2) checkOutput("wrapCount", 32'(count), 1);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
        checkOutput("emptyPopCount", 32'(count), 0);
        checkOutput("emptyPopC", 32'(c), 0);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
        checkOutput("emptyPopStill", 32'(count), 0);

        // Fill past full with the consumer stalled.
        for (int i = 0; i < 125; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
            if (i >= 123) checkOutput("fullInReady", 32'(in_ready), 0);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        checkOutput("fullCount", 32'(count), 123);
        checkOutput("fullMax", 32'(max_count), 123);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        checkOutput("afterPopCount", 32'(count), 122);
        checkOutput("afterPopInReady", 32'(in_ready), 1);
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0);
        end

        asyncReset();

        // Flush with a concurrent push keeps the high-water mark.
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h11, 8'h22, 2'd1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hAA, 8'h0F, 2'd2, 1'b0, 1'b0);
        checkOutput("flushCount", 32'(count), 0);
        checkOutput("flushOutValid", 32'(out_valid), 0);
        checkOutput("flushMax", 32'(max_count), 50);
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        checkOutput("postFlushCount", 32'(count), 1);
        checkOutput("postFlushC", 32'(c), 32'hA5);

        // Random traffic with occasional flushes and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) asyncReset();
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
